// File: rtl/xgmii_lb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xgmii_lb_pkg
// Brief   : Shared types and XGMII control characters for the loopback channel.
// Rev     : 1.0  initial release
// ============================================================================
package xgmii_lb_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_IDLE = 2'd1,
        MODE_LF   = 2'd2,
        MODE_ERR  = 2'd3
    } lb_mode_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } lb_state_e;

    localparam logic [7:0] c_char_idle  = 8'h07;
    localparam logic [7:0] c_char_start = 8'hFB;
    localparam logic [7:0] c_char_term  = 8'hFD;
    localparam logic [7:0] c_char_err   = 8'hFE;
    localparam logic [7:0] c_char_seq   = 8'h9C;

    // One 4-lane local-fault ordered set; wider buses replicate it
    localparam logic [31:0] c_lf_word32 = {8'h01, 8'h00, 8'h00, c_char_seq};
    localparam logic [3:0]  c_lf_ctrl4  = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/xgmii_lb_lane_ch.sv
`default_nettype none
// ============================================================================
// Module  : xgmii_lb_lane_ch
// Brief   : One loopback channel: frame FSM, error injector, delay line, stats.
// Rev     : 1.0  initial release
// ============================================================================
module xgmii_lb_lane_ch #(
    parameter int DATA_W    = 64,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = $clog2(MAX_DELAY + 1),
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_mode,
    input  logic [DLY_W-1:0]    i_delay,
    input  logic [15:0]         i_err_period,
    input  logic [DATA_W-1:0]   i_txd,
    input  logic [DATA_W/8-1:0] i_txc,
    output logic [DATA_W-1:0]   o_rxd,
    output logic [DATA_W/8-1:0] o_rxc,
    output logic [CNT_W-1:0]    o_frames,
    output logic [CNT_W-1:0]    o_err_inj,
    output logic                o_frame_active
);
    import xgmii_lb_pkg::*;

    localparam int c_lanes  = DATA_W / 8;
    localparam int c_ptr_w  = $clog2(MAX_DELAY);
    localparam int c_word_w = 2 + c_lanes + DATA_W;

    localparam logic [DATA_W-1:0]  c_idle_d  = {c_lanes{c_char_idle}};
    localparam logic [c_lanes-1:0] c_idle_c  = {c_lanes{1'b1}};
    localparam logic [DATA_W-1:0]  c_lf_d    = {(c_lanes/4){c_lf_word32}};
    localparam logic [c_lanes-1:0] c_lf_c    = {(c_lanes/4){c_lf_ctrl4}};
    localparam logic [DLY_W-1:0]   c_max_d   = DLY_W'(MAX_DELAY);
    localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};

    lb_state_e            r_state;
    lb_state_e            w_state_nxt;
    lb_mode_e             r_mode;
    lb_mode_e             w_mode_eff;
    lb_mode_e             w_rd_mode;
    logic                 w_start;
    logic                 w_term;
    logic                 w_frame_done;
    logic [15:0]          r_idx;
    logic [15:0]          w_idx_nxt;
    logic                 r_inj_pend;
    logic                 w_inj_set;
    logic [CNT_W-1:0]     r_frames;
    logic [CNT_W-1:0]     r_err_inj;

    logic [DLY_W-1:0]     w_d;
    logic [DLY_W-1:0]     r_d_q;
    logic [DLY_W-1:0]     r_fill;
    logic [DLY_W-1:0]     w_fill_eff;
    logic                 w_valid;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   w_rd_ptr;
    logic [c_word_w-1:0]  r_mem [MAX_DELAY];
    logic [c_word_w-1:0]  w_wr_word;
    logic [c_word_w-1:0]  w_rd_word;
    logic [DATA_W-1:0]    w_wr_txd;
    logic [c_lanes-1:0]   w_wr_txc;
    logic [DATA_W-1:0]    w_rd_txd;
    logic [c_lanes-1:0]   w_rd_txc;
    logic [DATA_W-1:0]    r_rxd;
    logic [c_lanes-1:0]   r_rxc;

    always_comb begin
        w_start = i_txc[0] && (i_txd[7:0] == c_char_start);
        w_term  = 1'b0;
        for (int i = 0; i < c_lanes; i++) begin
            if (i_txc[i] && (i_txd[8*i +: 8] == c_char_term)) begin
                w_term = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_term) begin
                        w_frame_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_IN_FRAME;
                    end
                end
            end
            ST_IN_FRAME: begin
                if (w_term) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // New mode is only accepted between frames, so a frame always completes
    always_comb begin
        w_mode_eff = r_mode;
        if ((r_state == ST_IDLE) && !w_start) begin
            w_mode_eff = lb_mode_e'(i_mode);
        end
        w_idx_nxt = (r_idx >= i_err_period) ? 16'd1 : r_idx + 16'd1;
        w_inj_set = (r_state == ST_IDLE) && w_start && !w_term &&
                    (r_mode == MODE_ERR) && (i_err_period != 16'd0) &&
                    (w_idx_nxt == i_err_period);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_PASS;
            r_idx      <= '0;
            r_inj_pend <= 1'b0;
            r_frames   <= '0;
            r_err_inj  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_eff;
            r_inj_pend <= w_inj_set;
            if (w_start) begin
                r_idx <= w_idx_nxt;
            end
            if (w_frame_done && (r_frames != c_cnt_max)) begin
                r_frames <= r_frames + CNT_W'(1);
            end
            if (r_inj_pend && (r_err_inj != c_cnt_max)) begin
                r_err_inj <= r_err_inj + CNT_W'(1);
            end
        end
    end

    // The mode travels through the delay line with its data word
    always_comb begin
        w_d        = (i_delay > c_max_d) ? c_max_d : i_delay;
        w_fill_eff = (w_d != r_d_q) ? '0 : r_fill;
        w_valid    = (w_fill_eff >= w_d);
        w_wr_txd   = r_inj_pend ? {i_txd[DATA_W-1:8], c_char_err} : i_txd;
        w_wr_txc   = r_inj_pend ? {i_txc[c_lanes-1:1], 1'b1} : i_txc;
        w_wr_word  = {w_mode_eff, w_wr_txc, w_wr_txd};
        w_rd_ptr   = r_wr_ptr - w_d[c_ptr_w-1:0];
        w_rd_word  = (w_d == '0) ? w_wr_word : r_mem[w_rd_ptr];
        w_rd_mode  = lb_mode_e'(w_rd_word[c_word_w-1 -: 2]);
        w_rd_txc   = w_rd_word[DATA_W +: c_lanes];
        w_rd_txd   = w_rd_word[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        r_mem[r_wr_ptr] <= w_wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_d_q    <= '0;
            r_rxd    <= c_idle_d;
            r_rxc    <= c_idle_c;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            r_d_q    <= w_d;
            r_fill   <= (w_fill_eff < c_max_d) ? w_fill_eff + DLY_W'(1) : w_fill_eff;
            if (!w_valid) begin
                r_rxd <= c_idle_d;
                r_rxc <= c_idle_c;
            end else begin
                case (w_rd_mode)
                    MODE_IDLE: begin
                        r_rxd <= c_idle_d;
                        r_rxc <= c_idle_c;
                    end
                    MODE_LF: begin
                        r_rxd <= c_lf_d;
                        r_rxc <= c_lf_c;
                    end
                    default: begin
                        r_rxd <= w_rd_txd;
                        r_rxc <= w_rd_txc;
                    end
                endcase
            end
        end
    end

    assign o_rxd          = r_rxd;
    assign o_rxc          = r_rxc;
    assign o_frames       = r_frames;
    assign o_err_inj      = r_err_inj;
    assign o_frame_active = (r_state == ST_IN_FRAME);

endmodule
`default_nettype wire

// File: rtl/xgmii_loopback_chan.sv
`default_nettype none
// ============================================================================
// Module  : xgmii_loopback_chan
// Brief   : Multi-channel XGMII tx-to-rx loopback with delay, modes and stats.
// Rev     : 1.0  initial release
// ============================================================================
module xgmii_loopback_chan #(
    parameter int NUM_CH    = 1,
    parameter int DATA_W    = 64,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = $clog2(MAX_DELAY + 1),
    parameter int CNT_W     = 32
) (
    input  logic                       clk_156m25,
    input  logic                       reset_156m25,
    input  logic [2*NUM_CH-1:0]        cfg_mode,
    input  logic [DLY_W*NUM_CH-1:0]    cfg_delay,
    input  logic [16*NUM_CH-1:0]       cfg_err_period,
    input  logic [DATA_W*NUM_CH-1:0]   xgmii_txd,
    input  logic [DATA_W/8*NUM_CH-1:0] xgmii_txc,
    output logic [DATA_W*NUM_CH-1:0]   xgmii_rxd,
    output logic [DATA_W/8*NUM_CH-1:0] xgmii_rxc,
    output logic [CNT_W*NUM_CH-1:0]    stat_frames,
    output logic [CNT_W*NUM_CH-1:0]    stat_err_inj,
    output logic [NUM_CH-1:0]          frame_active
);
    import xgmii_lb_pkg::*;

    localparam int c_lanes = DATA_W / 8;

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            xgmii_lb_lane_ch #(
                .DATA_W    (DATA_W),
                .MAX_DELAY (MAX_DELAY),
                .DLY_W     (DLY_W),
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk            (clk_156m25),
                .rst            (reset_156m25),
                .i_mode         (cfg_mode[2*ch +: 2]),
                .i_delay        (cfg_delay[DLY_W*ch +: DLY_W]),
                .i_err_period   (cfg_err_period[16*ch +: 16]),
                .i_txd          (xgmii_txd[DATA_W*ch +: DATA_W]),
                .i_txc          (xgmii_txc[c_lanes*ch +: c_lanes]),
                .o_rxd          (xgmii_rxd[DATA_W*ch +: DATA_W]),
                .o_rxc          (xgmii_rxc[c_lanes*ch +: c_lanes]),
                .o_frames       (stat_frames[CNT_W*ch +: CNT_W]),
                .o_err_inj      (stat_err_inj[CNT_W*ch +: CNT_W]),
                .o_frame_active (frame_active[ch])
            );
        end
    endgenerate

endmodule
`default_nettype wire
